uart_frame_parser: RTL and testbench
====================================

# uart_frame_parser

Receive-side frame decoder for the UART string link. Consumes the byte stream from the UART byte receiver (`rx_data`/`rx_vld`) and extracts `&&payload&&` frames. Delivers the packed payload, its byte count and a one-cycle done pulse to the command layer. Malformed, overlong or stalled frames are reported as errors and dropped.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz (informational; used only to derive the default `TIMEOUT_CLK`).
- `MAX_LEN`, 137: maximum payload bytes per frame; `frame_data` width = 8*MAX_LEN.
- `TIMEOUT_CLK`, 49_999: inter-byte idle limit in clocks (1 ms at 50 MHz) while inside a frame.
- `sys_clk`  in  1  system clock; single clock domain.
- `sys_rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte; valid only when `rx_vld`=1.
- `rx_vld`  in  1  one-cycle strobe per received byte; may assert on consecutive cycles.
- `frame_data`  out  8*MAX_LEN  payload; byte k occupies bits [8k+7:8k]; unused bytes are 0.
- `frame_len`  out  8  payload byte count (0..MAX_LEN).
- `frame_done`  out  1  one-cycle pulse when a complete frame is accepted.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted.
- `err_code`  out  2  cause of the last error: 1 = timeout, 2 = overflow, 3 = bad header; held until the next error.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, HDR1 (first `&` seen), CONTENT, TAIL1 (`&` seen inside content).
- IDLE:
  - `rx_vld` with `&` goes to HDR1.
  - Any other byte is ignored and does not set an error.
- HDR1:
  - `&` goes to CONTENT. Clear `frame_data` to 0 and `frame_len` to 0.
  - Any other byte goes to IDLE with `frame_err` and `err_code`=3.
- CONTENT:
  - `&` goes to TAIL1; nothing is stored.
  - Any other byte is stored at index `frame_len`, and `frame_len` increments.
  - If `frame_len`==MAX_LEN when a non-`&` byte arrives, the frame is aborted with overflow (`err_code`=2).
- TAIL1:
  - `&` completes the frame: pulse `frame_done` and go to IDLE.
  - Any other byte X means the earlier `&` was payload. Store `&` at `frame_len` and X at `frame_len`+1, add 2 to `frame_len`, and return to CONTENT.
  - If `frame_len`+2 > MAX_LEN in that case, abort with overflow (`err_code`=2).
- Empty frame `&&&&` is legal and completes with `frame_len`=0.
- A lone `&` inside the payload is data. A doubled `&&` always terminates the frame, so the payload can never contain `&&`.
- Timeout:
  - A 32-bit idle counter runs in HDR1, CONTENT and TAIL1.
  - The counter clears on every `rx_vld` and on entry to IDLE.
  - When the counter reaches TIMEOUT_CLK with no `rx_vld` in that cycle: pulse `frame_err`, set `err_code`=1, go to IDLE.
  - If `rx_vld` arrives in the same cycle the limit is reached, the byte wins and the counter clears.
- On any abort, `frame_data` and `frame_len` hold partial contents and are not valid. They stay valid only from `frame_done` until the next HDR1→CONTENT transition.
- Index arithmetic is 8-bit. The overflow checks above guarantee no write beyond byte MAX_LEN-1 and no `frame_len` wrap; MAX_LEN must be ≤ 253.
- Back-to-back frames need no gap. The byte after the closing `&` is processed in IDLE.

## Timing
- Reset (`sys_rst`=1 at a clock edge) forces state=IDLE and clears the idle counter. All outputs reset to 0: `frame_data`, `frame_len`, `frame_done`, `frame_err`, `err_code`, `busy`.
- Reset mid-frame discards the frame; no `frame_err` is issued.
- All outputs are registered.
- A byte accepted at edge N is reflected in state, `frame_len` and `frame_data` after edge N, i.e. visible in cycle N+1.
- The closing `&` accepted at edge N drives `frame_done`=1 for exactly cycle N+1. `frame_len` is final in the same cycle, and `busy`=0 from cycle N+1.
- For a timeout, `frame_err`=1 appears the cycle after the counter reaches TIMEOUT_CLK. `busy` drops in the same cycle.
- `frame_done` and `frame_err` never assert together.
- Throughput is one byte per clock in every state.

## Test plan
- `&&AB&&` with one byte every 10 clocks → `frame_done` once, `frame_len`=2, bytes 0/1 = 0x41/0x42, remaining bytes 0, `busy` low afterward.
- `&&a&b&&` → `frame_len`=3, payload `a`,`&`,`b`. Then `&&&&` → `frame_done`, `frame_len`=0, `frame_data` all zero.
- MAX_LEN=4: `&&ABCD&&` → done with len 4. `&&ABCDE` → `frame_err`, `err_code`=2 on the `E` byte. `&&ABC&x` → overflow on `x`.
- TIMEOUT_CLK=20: `&&AB`, then silence → `frame_err`, `err_code`=1 exactly 21 cycles after `B` is accepted. Repeat with a byte arriving on the limit cycle → no error.
- `&X` → `err_code`=3, then IDLE. Noise `xyz` in IDLE → no pulses. Consecutive-cycle `&&12&&&&34&&` → two `frame_done` pulses with payloads `12` and `34`.
- Assert `sys_rst` in the middle of `&&ABC` → all outputs 0 and no pulses. A following `&&Z&&` → `frame_len`=1, byte 0 = 0x5A.

Source files
------------

// File: rtl/uart_frame_parser_if.sv
// Byte-in / frame-out bundle between the UART byte receiver, the frame parser and the command layer.
// master = byte source and frame consumer side, slave = the parser itself.
interface uart_frame_parser_if #(
  parameter int unsigned MAX_LEN = 137
);
  logic [7:0]           rx_data;
  logic                 rx_vld;
  logic [8*MAX_LEN-1:0] frame_data;
  logic [7:0]           frame_len;
  logic                 frame_done;
  logic                 frame_err;
  logic [1:0]           err_code;
  logic                 busy;

  modport master (
    output rx_data, rx_vld,
    input  frame_data, frame_len, frame_done, frame_err, err_code, busy
  );

  modport slave (
    input  rx_data, rx_vld,
    output frame_data, frame_len, frame_done, frame_err, err_code, busy
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Extracts &&payload&& frames from the UART byte stream; one byte per clock, all outputs registered.
// A lone '&' in the payload is data, '&&' always closes; overflow, bad header and inter-byte stall abort the frame.
module uart_frame_parser #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned MAX_LEN     = 137,
  parameter int unsigned TIMEOUT_CLK = CLK_FREQ / 1000 - 1
) (
  input logic               sys_clk,
  input logic               sys_rst,
  uart_frame_parser_if.slave bus
);

  localparam logic [7:0] AMP          = 8'h26;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_HEADER   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR1,
    S_CONTENT,
    S_TAIL1
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          idle_q, idle_d;
  logic [7:0]           len_q, len_d;
  logic [8*MAX_LEN-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [1:0]           code_q, code_d;

  logic                 wr0, wr1;
  logic [7:0]           wr0_byte;
  logic                 is_amp;

  assign is_amp = (bus.rx_data == AMP);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    data_d   = data_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    idle_d   = idle_q;
    wr0      = 1'b0;
    wr1      = 1'b0;
    wr0_byte = bus.rx_data;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_vld && is_amp) state_d = S_HDR1;
      end
      S_HDR1: begin
        if (bus.rx_vld) begin
          if (is_amp) begin
            state_d = S_CONTENT;
            len_d   = '0;
            data_d  = '0;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_HEADER;
          end
        end
      end
      S_CONTENT: begin
        if (bus.rx_vld) begin
          if (is_amp) begin
            state_d = S_TAIL1;
          end else if (len_q == 8'(MAX_LEN)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_OVERFLOW;
          end else begin
            wr0   = 1'b1;
            len_d = len_q + 8'd1;
          end
        end
      end
      S_TAIL1: begin
        if (bus.rx_vld) begin
          if (is_amp) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (({1'b0, len_q} + 9'd2) > 9'(MAX_LEN)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_OVERFLOW;
          end else begin
            // the held '&' turned out to be payload: store it, then the current byte
            wr0      = 1'b1;
            wr0_byte = AMP;
            wr1      = 1'b1;
            len_d    = len_q + 8'd2;
            state_d  = S_CONTENT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // a byte arriving on the limit cycle wins over the timeout
    if (state_q != S_IDLE && !bus.rx_vld && idle_q >= TIMEOUT_CLK) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
    end

    idle_d = (bus.rx_vld || state_d == S_IDLE) ? '0 : idle_q + 32'd1;

    for (int k = 0; k < int'(MAX_LEN); k++) begin
      if (wr0 && k == int'(len_q))     data_d[8*k +: 8] = wr0_byte;
      if (wr1 && k == int'(len_q) + 1) data_d[8*k +: 8] = bus.rx_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      idle_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      len_q   <= len_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign bus.frame_data = data_q;
  assign bus.frame_len  = len_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;
  assign bus.err_code   = code_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed and random byte streams into uart_frame_parser (MAX_LEN=4, TIMEOUT_CLK=20),
// checked every cycle against a string-level frame model.
module tb_uart_frame_parser;

  localparam int unsigned MAXL = 4;
  localparam int unsigned TO   = 20;
  localparam logic [7:0]  AMP  = 8'h26;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;

  uart_frame_parser_if #(.MAX_LEN(MAXL)) bus ();

  uart_frame_parser #(
    .CLK_FREQ   (50_000_000),
    .MAX_LEN    (MAXL),
    .TIMEOUT_CLK(TO)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int fails  = 0;

  // model: raw bytes received since the opening '&' of the current frame
  logic [7:0]  raw[$];
  int          idle = 0;
  bit          exp_done, exp_err, exp_rst;
  logic [1:0]  exp_code = 2'd0;
  int          exp_len;
  logic [31:0] exp_data;

  int          done_seen = 0, err_seen = 0;
  logic [7:0]  last_len;
  logic [31:0] last_data;
  logic [1:0]  last_code;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int stored_count();
    int n;
    n = raw.size() - 2;
    if (n > 0 && raw[raw.size()-1] == AMP) return n - 1;
    return n;
  endfunction

  task automatic model_byte(input logic [7:0] d);
    int n;
    if (raw.size() == 0) begin
      if (d == AMP) raw.push_back(d);
      return;
    end
    raw.push_back(d);
    if (raw[1] != AMP) begin
      exp_err = 1; exp_code = 2'd3; raw.delete();
      return;
    end
    n = raw.size() - 2;
    if (n >= 2 && raw[raw.size()-1] == AMP && raw[raw.size()-2] == AMP) begin
      exp_done = 1;
      exp_len  = n - 2;
      exp_data = '0;
      for (int i = 0; i < n - 2; i++) exp_data = exp_data | (32'(raw[2+i]) << (8*i));
      raw.delete();
      return;
    end
    if (stored_count() > int'(MAXL)) begin
      exp_err = 1; exp_code = 2'd2; raw.delete();
    end
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
    exp_done = 0; exp_err = 0; exp_rst = 0;
    if (r) begin
      raw.delete(); idle = 0; exp_code = 2'd0; exp_rst = 1;
    end else if (v) begin
      idle = 0;
      model_byte(d);
    end else if (raw.size() > 0) begin
      idle++;
      // counter reaches the limit after TO idle edges; the abort lands on the next one
      if (idle == int'(TO) + 1) begin
        exp_err = 1; exp_code = 2'd1; raw.delete(); idle = 0;
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    bus.rx_vld  = v;
    bus.rx_data = d;
    sys_rst     = r;
    @(posedge sys_clk);
    model_edge(v, d, r);
    #1;
    check("busy", 64'(bus.busy), 64'(raw.size() > 0));
    check("frame_done", 64'(bus.frame_done), 64'(exp_done));
    check("frame_err", 64'(bus.frame_err), 64'(exp_err));
    check("err_code", 64'(bus.err_code), 64'(exp_code));
    if (raw.size() >= 2) check("len_in_frame", 64'(bus.frame_len), 64'(stored_count()));
    if (exp_done) begin
      check("done_len", 64'(bus.frame_len), 64'(exp_len));
      check("done_data", 64'(bus.frame_data), 64'(exp_data));
    end
    if (exp_rst) begin
      check("rst_len", 64'(bus.frame_len), 64'd0);
      check("rst_data", 64'(bus.frame_data), 64'd0);
    end
    if (bus.frame_done) begin
      done_seen++; last_len = bus.frame_len; last_data = bus.frame_data;
    end
    if (bus.frame_err) begin
      err_seen++; last_code = bus.err_code;
    end
    bus.rx_vld = 1'b0;
    sys_rst    = 1'b0;
  endtask

  task automatic send(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      cyc(1'b1, s[i], 1'b0);
      repeat (gap) cyc(1'b0, 8'h00, 1'b0);
    end
  endtask

  initial begin
    int d0, e0, lat, r;
    bus.rx_vld  = 1'b0;
    bus.rx_data = 8'h00;

    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_code", 64'(bus.err_code), 64'd0);

    d0 = done_seen;
    send("&&AB&&", 9);
    check("AB_done_count", 64'(done_seen - d0), 64'd1);
    check("AB_len", 64'(last_len), 64'd2);
    check("AB_data", 64'(last_data), 64'h0000_4241);

    send("&&a&b&&", 0);
    check("amp_len", 64'(last_len), 64'd3);
    check("amp_data", 64'(last_data), 64'h0062_2661);
    send("&&&&", 0);
    check("empty_len", 64'(last_len), 64'd0);
    check("empty_data", 64'(last_data), 64'd0);

    send("&&ABCD&&", 0);
    check("full_len", 64'(last_len), 64'd4);
    check("full_data", 64'(last_data), 64'h4443_4241);

    e0 = err_seen;
    send("&&ABCDE", 0);
    check("ovf_content_err", 64'(err_seen - e0), 64'd1);
    check("ovf_content_code", 64'(last_code), 64'd2);
    e0 = err_seen;
    send("&&ABC&x", 0);
    check("ovf_tail_err", 64'(err_seen - e0), 64'd1);
    check("ovf_tail_code", 64'(last_code), 64'd2);

    send("&&AB", 0);
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      cyc(1'b0, 8'h00, 1'b0);
      if (bus.frame_err) lat = k;
    end
    check("timeout_latency", 64'(lat), 64'd21);
    check("timeout_code", 64'(last_code), 64'd1);

    e0 = err_seen; d0 = done_seen;
    send("&&AB", 0);
    repeat (20) cyc(1'b0, 8'h00, 1'b0);
    send("C&&", 0);
    check("limit_byte_no_err", 64'(err_seen - e0), 64'd0);
    check("limit_byte_done", 64'(done_seen - d0), 64'd1);
    check("limit_byte_data", 64'(last_data), 64'h0043_4241);

    e0 = err_seen;
    send("&X", 0);
    check("hdr_err", 64'(err_seen - e0), 64'd1);
    check("hdr_code", 64'(last_code), 64'd3);
    e0 = err_seen; d0 = done_seen;
    send("xyz", 1);
    check("noise_no_pulse", 64'((err_seen - e0) + (done_seen - d0)), 64'd0);

    d0 = done_seen;
    send("&&12&&&&34&&", 0);
    check("b2b_count", 64'(done_seen - d0), 64'd2);
    check("b2b_last", 64'(last_data), 64'h0000_3433);

    e0 = err_seen; d0 = done_seen;
    send("&&ABC", 0);
    cyc(1'b0, 8'h00, 1'b1);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_len", 64'(bus.frame_len), 64'd0);
    check("midrst_data", 64'(bus.frame_data), 64'd0);
    check("midrst_pulses", 64'((err_seen - e0) + (done_seen - d0)), 64'd0);
    send("&&Z&&", 0);
    check("after_rst_len", 64'(last_len), 64'd1);
    check("after_rst_data", 64'(last_data), 64'h0000_005A);

    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2)       cyc(1'b0, 8'h00, 1'b1);
      else if (r < 42) cyc(1'b1, AMP, 1'b0);
      else if (r < 75) cyc(1'b1, 8'($urandom_range(32, 126)), 1'b0);
      else if (r < 96) cyc(1'b0, 8'h00, 1'b0);
      else repeat ($urandom_range(18, 24)) cyc(1'b0, 8'h00, 1'b0);
    end
    repeat (25) cyc(1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
